// File: rtl/comb_y2_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// comb_y2_sweep_ctrl_pkg
//   Shared definitions for the comb_Y2 sweep controller:
//   - FSM state encoding (IDLE / RUN / SETTLE)
//   - default input width and default golden truth table
//   - small helper for the terminal-code compare
// -----------------------------------------------------------------------------
package comb_y2_sweep_ctrl_pkg;

  // Sweep sequencer states; SETTLE is only reachable when the settle
  // cycle option is built in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2
  } sweep_state_e;

  localparam int          DEFAULT_N_IN     = 4;
  localparam logic [15:0] DEFAULT_EXPECTED = 16'h0000;

  // True when the code being sampled is the last one of the sweep.
  // Termination is decided by this compare, never by counter overflow.
  function automatic logic is_last_code(input int unsigned code, input int unsigned tw);
    return (code == (tw - 32'd1));
  endfunction

endpackage

// File: rtl/comb_y2_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// comb_y2_sweep_ctrl
//   Sequencer for the comb_Y2 combinational block. On an accepted start it
//   drives abcd through all 2**N_IN codes in ascending order, captures y_in
//   for each code into truth_table (bit k <-> code k), and at the end compares
//   the captured table with EXPECTED.
//
//   Build option: define SWEEP_SETTLE_EN to insert a SETTLE cycle before each
//   RUN sample cycle (abcd changes on entry to SETTLE, y_in sampled in RUN),
//   doubling the sweep length. Undefined: one cycle per code.
//
// Ports
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous reset, active high
//   start        in   sweep request, only honoured while idle
//   y_in         in   Y output of comb_Y2
//   abcd         out  drive to comb_Y2 {A,B,C,D}, MSB = A
//   busy         out  sweep in progress
//   done         out  one-cycle pulse when the sweep completes
//   truth_table  out  captured Y per code
//   mismatch     out  truth_table != EXPECTED, valid from done onward
// -----------------------------------------------------------------------------
module comb_y2_sweep_ctrl
  import comb_y2_sweep_ctrl_pkg::*;
#(
  parameter int                      N_IN     = DEFAULT_N_IN,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = DEFAULT_EXPECTED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   y_in,
  output logic [N_IN-1:0]        abcd,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   truth_table,
  output logic                   mismatch
);

  localparam int              TW        = 2**N_IN;
  localparam logic [N_IN-1:0] ABCD_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] ABCD_ONE  = N_IN'(1);

`ifdef SWEEP_SETTLE_EN
  // The first code also gets its settle cycle.
  localparam sweep_state_e ST_FIRST = ST_SETTLE;
  localparam sweep_state_e ST_NEXT  = ST_SETTLE;
`else
  localparam sweep_state_e ST_FIRST = ST_RUN;
  localparam sweep_state_e ST_NEXT  = ST_RUN;
`endif

  sweep_state_e      r_state;
  logic [N_IN-1:0]   r_abcd;
  logic              r_busy;
  logic              r_done;
  logic [TW-1:0]     r_tt;
  logic              r_mismatch;

  logic [TW-1:0]     w_tt_next;
  logic              w_last;

  // Table with the current sample merged in; on the final code this already
  // contains the last bit, so the compare below covers every code.
  always_comb begin
    w_tt_next         = r_tt;
    w_tt_next[r_abcd] = y_in;
    w_last            = is_last_code(32'(r_abcd), 32'(TW));
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_abcd     <= ABCD_ZERO;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tt       <= {TW{1'b0}};
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= ST_FIRST;
            r_busy     <= 1'b1;
            r_abcd     <= ABCD_ZERO;
            r_tt       <= {TW{1'b0}};
            r_mismatch <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_tt <= w_tt_next;
          if (!w_last) begin
            r_abcd  <= r_abcd + ABCD_ONE;
            r_state <= ST_NEXT;
          end else begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_mismatch <= (w_tt_next != EXPECTED);
          end
        end
        ST_SETTLE: begin
`ifdef SWEEP_SETTLE_EN
          // abcd already holds the new code; sample it on the next edge.
          r_state <= ST_RUN;
`else
          // Not reachable in this build; drop back to a safe idle.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign abcd        = r_abcd;
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_tt;
  assign mismatch    = r_mismatch;

endmodule
